// File: rtl/dc_axil_reg_slave_pkg.sv
// Shared register indices, response codes and the byte-strobe merge used by the
// display controller's AXI4-Lite control-register slave.
package dc_axil_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_HRES   = 2'd1;
  localparam logic [1:0] REG_VRES   = 2'd2;
  localparam logic [1:0] REG_FBADDR = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [31:0] axil_reg_t;

  function automatic axil_reg_t wstrb_merge(input axil_reg_t old_val,
                                            input axil_reg_t new_val,
                                            input logic [3:0] strb);
    axil_reg_t res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dc_axil_reg_slave.sv
// AXI4-Lite slave holding four 32-bit display control registers, with a one-cycle
// write strobe per register. All AXI outputs come straight from flops.
module dc_axil_reg_slave
  import dc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  localparam int NUM_REGS = 2 ** (C_S_AXI_ADDR_WIDTH - 2)
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          REG_Q,
  output logic [NUM_REGS-1:0]             REG_WR_PULSE
);

  localparam int SEL_W = C_S_AXI_ADDR_WIDTH - 2;
  typedef logic [SEL_W-1:0] sel_t;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("dc_axil_reg_slave supports only a 32-bit data bus");
  end

  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  sel_t                aw_sel_q, aw_sel_d;
  axil_reg_t           w_data_q, w_data_d;
  logic [3:0]          w_strb_q, w_strb_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  axil_reg_t           regs_q [NUM_REGS];
  axil_reg_t           regs_d [NUM_REGS];
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  axil_reg_t           rdata_q, rdata_d;

  logic      aw_hs, w_hs, commit, ar_hs;
  sel_t      commit_sel;
  axil_reg_t commit_data;
  logic [3:0] commit_strb;

  // Write channel: each half may arrive alone and wait in its holding register.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && awready_q;
    w_hs        = S_AXI_WVALID && wready_q;
    commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    commit_sel  = aw_held_q ? aw_sel_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    commit_data = w_held_q ? w_data_q : S_AXI_WDATA;
    commit_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;

    aw_sel_d   = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_sel_q;
    w_data_d   = w_hs ? S_AXI_WDATA : w_data_q;
    w_strb_d   = w_hs ? S_AXI_WSTRB : w_strb_q;
    aw_held_d  = commit ? 1'b0 : (aw_held_q || aw_hs);
    w_held_d   = commit ? 1'b0 : (w_held_q || w_hs);
    bvalid_d   = commit ? 1'b1 : (bvalid_q && !S_AXI_BREADY);
    awready_d  = !aw_held_d && !bvalid_d;
    wready_d   = !w_held_d && !bvalid_d;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit) begin
      regs_d[commit_sel]     = wstrb_merge(regs_q[commit_sel], commit_data, commit_strb);
      wr_pulse_d[commit_sel] = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_sel_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_sel_q   <= aw_sel_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Read samples regs_q, so a same-cycle commit is seen only by later reads.
  always_comb begin
    ar_hs     = S_AXI_ARVALID && arready_q;
    rvalid_d  = ar_hs ? 1'b1 : (rvalid_q && !S_AXI_RREADY);
    arready_d = !rvalid_d;
    rdata_d   = ar_hs ? regs_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]] : rdata_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg_q
    assign REG_Q[32*n +: 32] = regs_q[n];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign REG_WR_PULSE  = wr_pulse_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_dc_axil_reg_slave.sv
// Directed bench for dc_axil_reg_slave: drives and samples on the falling edge.
module tb_dc_axil_reg_slave;
  import dc_axil_pkg::*;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [3:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b1;
  logic [3:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b1;
  logic [127:0] REG_Q;
  logic [3:0]   REG_WR_PULSE;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [4] = '{default: 0};

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK)
    for (int i = 0; i < 4; i++) if (REG_WR_PULSE[i]) pulse_cnt[i]++;

  dc_axil_reg_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG_Q(REG_Q), .REG_WR_PULSE(REG_WR_PULSE)
  );

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL wr_timeout addr=%h n=%0d limit=20", addr, n); end
    checks++;
    if (S_AXI_BRESP !== RESP_OKAY) begin errors++; $display("FAIL bresp got=%b exp=00", S_AXI_BRESP); end
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL rd_timeout addr=%h n=%0d limit=20", addr, n); end
    data = S_AXI_RDATA;
    checks++;
    if (S_AXI_RRESP !== RESP_OKAY) begin errors++; $display("FAIL rresp got=%b exp=00", S_AXI_RRESP); end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, REG_WR_PULSE} !== 9'h0 ||
        S_AXI_RDATA !== 32'h0 || REG_Q !== 128'h0) begin
      errors++;
      $display("FAIL reset_state rdy/vld=%b rdata=%h regq=%h exp all 0",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, REG_WR_PULSE},
               S_AXI_RDATA, REG_Q);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    int p0 [4];
    logic [31:0] rd;
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      checks++;
      if (rd !== 32'(i + 1)) begin errors++; $display("FAIL basic_read%0d got=%h exp=%h", i, rd, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pulse_cnt[i] - p0[i] !== 1) begin
        errors++; $display("FAIL basic_pulse%0d got=%0d exp=1", i, pulse_cnt[i] - p0[i]);
      end
    end
    checks++;
    if (REG_Q !== {32'h4, 32'h3, 32'h2, 32'h1}) begin errors++; $display("FAIL basic_regq got=%h", REG_Q); end
  endtask

  task automatic test_latency();
    S_AXI_AWADDR = {REG_FBADDR, 2'b00}; S_AXI_WDATA = 32'h44; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b1 || REG_WR_PULSE !== 4'b1000 || S_AXI_AWREADY !== 1'b0 || REG_Q[127:96] !== 32'h44) begin
      errors++; $display("FAIL lat_commit bvalid=%b pulse=%b awrdy=%b reg3=%h exp 1/1000/0/44",
                         S_AXI_BVALID, REG_WR_PULSE, S_AXI_AWREADY, REG_Q[127:96]);
    end
    S_AXI_WDATA = 32'h4;
    @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b0 || REG_WR_PULSE !== 4'b0000 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
      errors++; $display("FAIL lat_idle bvalid=%b pulse=%b aw/wrdy=%b%b exp 0/0000/11",
                         S_AXI_BVALID, REG_WR_PULSE, S_AXI_AWREADY, S_AXI_WREADY);
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || REG_Q[127:96] !== 32'h4) begin
      errors++; $display("FAIL lat_b2b bvalid=%b reg3=%h exp 1/4", S_AXI_BVALID, REG_Q[127:96]);
    end
    @(negedge ACLK);
  endtask

  task automatic test_order();
    S_AXI_AWADDR = {REG_VRES, 2'b00}; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    checks++;
    if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1) begin
      errors++; $display("FAIL aw_first_held awrdy=%b wrdy=%b exp 0/1", S_AXI_AWREADY, S_AXI_WREADY);
    end
    repeat (2) @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b0 || REG_Q[95:64] !== 32'h3) begin
      errors++; $display("FAIL aw_first_wait bvalid=%b reg2=%h exp 0/3", S_AXI_BVALID, REG_Q[95:64]);
    end
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || REG_Q[95:64] !== 32'hDEADBEEF || REG_WR_PULSE !== 4'b0100) begin
      errors++; $display("FAIL aw_first_commit bvalid=%b reg2=%h pulse=%b exp 1/deadbeef/0100",
                         S_AXI_BVALID, REG_Q[95:64], REG_WR_PULSE);
    end
    @(negedge ACLK);
    S_AXI_WDATA = 32'h0BADF00D; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    checks++;
    if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
      errors++; $display("FAIL w_first_held wrdy=%b awrdy=%b exp 0/1", S_AXI_WREADY, S_AXI_AWREADY);
    end
    repeat (2) @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b0 || REG_Q[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL w_first_wait bvalid=%b reg2=%h exp 0/deadbeef", S_AXI_BVALID, REG_Q[95:64]);
    end
    S_AXI_AWADDR = {REG_VRES, 2'b00}; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || REG_Q[95:64] !== 32'h0BADF00D) begin
      errors++; $display("FAIL w_first_commit bvalid=%b reg2=%h exp 1/0badf00d", S_AXI_BVALID, REG_Q[95:64]);
    end
    @(negedge ACLK);
  endtask

  task automatic test_strobe();
    int p0;
    axi_write({REG_CTRL, 2'b00}, 32'h11223344, 4'hF);
    axi_write({REG_CTRL, 2'b01}, 32'hAABBCCDD, 4'b0101);
    checks++;
    if (REG_Q[31:0] !== 32'h11BB33DD) begin errors++; $display("FAIL strb_0101 got=%h exp=11bb33dd", REG_Q[31:0]); end
    p0 = pulse_cnt[0];
    axi_write({REG_CTRL, 2'b00}, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if (REG_Q[31:0] !== 32'h11BB33DD || pulse_cnt[0] - p0 !== 1) begin
      errors++; $display("FAIL strb_zero reg0=%h pulses=%0d exp 11bb33dd/1", REG_Q[31:0], pulse_cnt[0] - p0);
    end
  endtask

  task automatic test_backpressure();
    S_AXI_AWADDR = {REG_CTRL, 2'b00}; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = {REG_HRES, 2'b00}; S_AXI_WDATA = 32'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0 || REG_Q[63:32] !== 32'h2) begin
        errors++; $display("FAIL b_stall%0d bvalid=%b aw/wrdy=%b%b reg1=%h exp 1/00/2",
                           i, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, REG_Q[63:32]);
      end
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || REG_Q[63:32] !== 32'h2) begin
      errors++; $display("FAIL b_release bvalid=%b aw/wrdy=%b%b reg1=%h exp 0/11/2",
                         S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, REG_Q[63:32]);
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || REG_Q[63:32] !== 32'h77 || REG_WR_PULSE !== 4'b0010) begin
      errors++; $display("FAIL b_second bvalid=%b reg1=%h pulse=%b exp 1/77/0010",
                         S_AXI_BVALID, REG_Q[63:32], REG_WR_PULSE);
    end
    @(negedge ACLK);
    S_AXI_ARADDR = {REG_CTRL, 2'b00}; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    axi_write({REG_CTRL, 2'b00}, 32'h12345678, 4'hF);
    repeat (2) @(negedge ACLK);
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA5A5A5A5 || S_AXI_ARREADY !== 1'b0 ||
        REG_Q[31:0] !== 32'h12345678) begin
      errors++; $display("FAIL r_stall rvalid=%b rdata=%h arrdy=%b reg0=%h exp 1/a5a5a5a5/0/12345678",
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY, REG_Q[31:0]);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL r_release rvalid=%b arrdy=%b exp 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    axi_write({REG_HRES, 2'b00}, 32'h2, 4'hF);
    S_AXI_AWADDR = {REG_HRES, 2'b00}; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = {REG_HRES, 2'b00};
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h2 || S_AXI_BVALID !== 1'b1 || REG_Q[63:32] !== 32'h55) begin
      errors++; $display("FAIL collide rvalid=%b rdata=%h bvalid=%b reg1=%h exp 1/2/1/55",
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, REG_Q[63:32]);
    end
    @(negedge ACLK);
    axi_read({REG_HRES, 2'b00}, rd);
    checks++;
    if (rd !== 32'h55) begin errors++; $display("FAIL collide_next got=%h exp=55", rd); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    S_AXI_ARADDR = {REG_CTRL, 2'b00}; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR = {REG_FBADDR, 2'b00}; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    #1 ARESETN = 1'b0;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, REG_WR_PULSE} !== 9'h0 ||
        S_AXI_RDATA !== 32'h0 || REG_Q !== 128'h0) begin
      errors++; $display("FAIL mid_reset rdy/vld=%b rdata=%h regq=%h exp all 0",
                         {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, REG_WR_PULSE},
                         S_AXI_RDATA, REG_Q);
    end
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL mid_ready got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    for (int i = 0; i < 8; i++) begin
      if (S_AXI_BVALID || S_AXI_RVALID || REG_WR_PULSE != 4'h0) seen++;
      @(negedge ACLK);
    end
    checks++;
    if (seen !== 0 || REG_Q !== 128'h0) begin
      errors++; $display("FAIL mid_no_resp cycles_with_resp=%0d regq=%h exp 0/0", seen, REG_Q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_order();
    test_strobe();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_axil_reg_slave.md
Name: dc_axil_reg_slave

Overview:
AXI4-Lite responder that terminates the display controller's S00_AXI control port. It holds a bank of four 32-bit read/write control registers and presents their contents to the display datapath. It also emits a per-register write pulse. It is the slave end of the AXI4-Lite traffic that the master VIP bench drives: sequential single-beat writes to 0x0–0xC, then read-back.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported, and elaboration fails otherwise.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register.
NUM_REGS, 4, number of registers; fixed at 2**(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  single clock; all logic is rising-edge.
ARESETN  in  1  reset, asynchronous and active-low.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
REG_Q  out  NUM_REGS*32  register contents, flat; reg n occupies [32n+31:32n].
REG_WR_PULSE  out  NUM_REGS  one-cycle strobe; bit n pulses on a commit to reg n.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers are 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and REG_WR_PULSE are 0.
  - RDATA is 0.
  - The first READY may rise on the first ACLK edge after ARESETN deasserts.
- Write channel: AW and W are accepted independently, each into a one-entry holding register with its own "held" flag.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. Both are registered.
  - AW and W may arrive in either order, in the same cycle, or any number of cycles apart.
  - Commit happens in the cycle where both are held (or arriving) and BVALID=0:
    - Merge: reg[sel] byte k <= WDATA byte k where WSTRB[k]=1, otherwise unchanged. sel = AWADDR[3:2]; AWADDR[1:0] is ignored.
    - Clear both held flags.
    - Set BVALID=1 on the next edge.
    - Pulse REG_WR_PULSE[sel] for exactly the one cycle following the commit, in the same cycle BVALID first rises.
  - BVALID stays high until BVALID&&BREADY. While BVALID=1, neither AWREADY nor WREADY asserts, so at most one write is in flight.
  - Minimum latency from simultaneous AW+W handshake to BVALID: 1 cycle. Back-to-back writes run at 1 write per 2 cycles with BREADY tied high.
  - WSTRB=0: the commit and response still occur, the register is unchanged, and the pulse still fires.
- Read channel:
  - ARREADY = !RVALID (registered).
  - On AR handshake: RDATA <= reg[ARADDR[3:2]] and RVALID <= 1 on the next edge.
  - RDATA and RVALID are held stable until RVALID&&RREADY, then RVALID drops; ARREADY rises the same edge.
  - Throughput is 1 read per 2 cycles.
- Read/write collision: an AR handshake in the same cycle as a commit to the same register returns the pre-commit value. The read sees the new value from the following cycle on.
- Address range: every address decodes to a register, so no SLVERR/DECERR is ever generated.
- Reset mid-transaction: held AW/W and pending B/R are discarded and registers clear. No response is ever issued for a transaction that was in progress when reset asserted.
- AXI rule: VALID outputs never depend combinationally on READY inputs; all outputs are registered.

Decomposition:
- Package dc_axil_pkg holds:
  - localparams REG_CTRL=2'd0, REG_HRES=2'd1, REG_VRES=2'd2, REG_FBADDR=2'd3 (register indices);
  - RESP_OKAY=2'b00;
  - typedef axil_reg_t = logic [31:0];
  - function wstrb_merge(old, new, strb).
- No sub-module needed. Write and read channels are two always_ff blocks in the single module; the byte merge is the package function.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> RDATA 0x1..0x4, every BRESP/RRESP=0, REG_WR_PULSE bits 0..3 each pulse once.
2. AWVALID asserted 3 cycles before WVALID (and the reverse order), addr 0x8, data 0xDEADBEEF -> a single commit only after both handshakes, BVALID one cycle later, REG_Q[95:64]=0xDEADBEEF.
3. Reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg0=0x11BB33DD; a second write with WSTRB=0 -> value unchanged, BVALID still issued.
4. Hold BREADY low 5 cycles after a write while the master presents a second AW/W -> BVALID stays 1, AWREADY/WREADY stay 0; the second write commits only after the B handshake. Same check on the R channel with RREADY low: RDATA stable.
5. Same-cycle AR to 0x4 and commit of 0x55 to 0x4 (old value 0x2) -> RDATA=0x2; the next read returns 0x55.
6. Assert ARESETN low while AW is held, W is pending and RVALID=1 -> all READY/VALID go 0 immediately, REG_Q=0, and no B or R is issued after release.
